// File: rtl/playfield_renderer_if.sv
// Pixel-stream and board-lookup bus between the video timing / board store
// (master) and the playfield renderer (slave).
interface playfield_renderer_if #(
    parameter int COLS = 10,
    parameter int ROWS = 20
);
    logic                    p_tick;
    logic                    visible;
    logic [9:0]              pixel_x;
    logic [9:0]              pixel_y;
    logic [$clog2(COLS)-1:0] cell_x;
    logic [$clog2(ROWS)-1:0] cell_y;
    logic [2:0]              cell_kind;
    logic                    grid_en;
    logic [ROWS-1:0]         row_flash;
    logic [11:0]             rgb;

    modport master (
        output p_tick, visible, pixel_x, pixel_y, cell_kind, grid_en, row_flash,
        input  cell_x, cell_y, rgb
    );

    modport slave (
        input  p_tick, visible, pixel_x, pixel_y, cell_kind, grid_en, row_flash,
        output cell_x, cell_y, rgb
    );
endinterface

// File: rtl/playfield_renderer.sv
// Two-stage playfield renderer: running counters locate the board cell for the
// current pixel (stage 1), then the looked-up cell kind is turned into a colour (stage 2).
module playfield_renderer #(
    parameter int          ORG_X        = 220,
    parameter int          ORG_Y        = 40,
    parameter int          CELL         = 20,
    parameter int          COLS         = 10,
    parameter int          ROWS         = 20,
    parameter logic [95:0] PALETTE      = {12'hF00, 12'h80C, 12'h0F3, 12'hFF0,
                                           12'hD90, 12'h04F, 12'h09D, 12'h000},
    parameter logic [11:0] BG_RGB       = 12'h111,
    parameter logic [11:0] GRID_RGB     = 12'h333,
    parameter logic [11:0] FLASH_RGB    = 12'hFFF,
    parameter int          FLASH_FRAMES = 8
) (
    input logic                 clk,
    input logic                 reset,
    playfield_renderer_if.slave bus
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int SW = $clog2(CELL);
    localparam int FW = $clog2(FLASH_FRAMES + 1);

    localparam logic [9:0]    X0         = 10'(ORG_X);
    localparam logic [9:0]    Y0         = 10'(ORG_Y);
    localparam logic [10:0]   X_END      = 11'(ORG_X + COLS * CELL);
    localparam logic [10:0]   Y_END      = 11'(ORG_Y + ROWS * CELL);
    localparam logic [SW-1:0] SUB_LAST   = SW'(CELL - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FLASH_FRAMES - 1);

    logic [SW-1:0] sub_x_q, sub_x_d, sub_y_q, sub_y_d;
    logic [CW-1:0] col_q, col_d, cell_x_q, cell_x_d;
    logic [RW-1:0] row_q, row_d, cell_y_q, cell_y_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          blink_q, blink_d, synced_q, synced_d;
    logic          inside_q, inside_d, edge_x_q, edge_x_d, edge_y_q, edge_y_d;
    logic          flash_q, flash_d;
    logic [11:0]   rgb_q, rgb_d;

    logic          at_x0, at_org, at_frame, in_x, in_y;

    assign at_x0    = (bus.pixel_x == X0);
    assign at_org   = at_x0 && (bus.pixel_y == Y0);
    assign at_frame = (bus.pixel_x == '0) && (bus.pixel_y == '0);
    assign in_x     = ({1'b0, bus.pixel_x} >= {1'b0, X0}) && ({1'b0, bus.pixel_x} < X_END);
    assign in_y     = ({1'b0, bus.pixel_y} >= {1'b0, Y0}) && ({1'b0, bus.pixel_y} < Y_END);

    always_comb begin
        sub_x_d  = sub_x_q;
        col_d    = col_q;
        sub_y_d  = sub_y_q;
        row_d    = row_q;
        frame_d  = frame_q;
        blink_d  = blink_q;
        synced_d = synced_q;
        cell_x_d = cell_x_q;
        cell_y_d = cell_y_q;
        inside_d = inside_q;
        edge_x_d = edge_x_q;
        edge_y_d = edge_y_q;
        flash_d  = flash_q;
        rgb_d    = rgb_q;

        if (bus.p_tick) begin
            // Counters are advanced combinationally so stage 1 sees the values
            // belonging to the pixel presented on this very tick.
            if (at_x0) begin
                sub_x_d = '0;
                col_d   = '0;
            end else if (sub_x_q == SUB_LAST) begin
                sub_x_d = '0;
                if (col_q != COL_LAST) col_d = col_q + 1'b1;
            end else begin
                sub_x_d = sub_x_q + 1'b1;
            end

            if (at_org) begin
                sub_y_d = '0;
                row_d   = '0;
            end else if (at_x0) begin
                if (sub_y_q == SUB_LAST) begin
                    sub_y_d = '0;
                    if (row_q != ROW_LAST) row_d = row_q + 1'b1;
                end else begin
                    sub_y_d = sub_y_q + 1'b1;
                end
            end

            if (at_frame) begin
                if (frame_q == FRAME_LAST) begin
                    frame_d = '0;
                    blink_d = ~blink_q;
                end else begin
                    frame_d = frame_q + 1'b1;
                end
            end

            synced_d = synced_q | at_org;

            cell_x_d = col_d;
            cell_y_d = row_d;
            inside_d = in_x && in_y && bus.visible && synced_d;
            edge_x_d = (sub_x_d == '0);
            edge_y_d = (sub_y_d == '0);
            flash_d  = bus.row_flash[row_d];

            if (!inside_q)                              rgb_d = BG_RGB;
            else if (bus.grid_en && (edge_x_q || edge_y_q)) rgb_d = GRID_RGB;
            else if (flash_q && blink_q)                rgb_d = FLASH_RGB;
            else                                        rgb_d = PALETTE[int'(bus.cell_kind) * 12 +: 12];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sub_x_q  <= '0;
            col_q    <= '0;
            sub_y_q  <= '0;
            row_q    <= '0;
            frame_q  <= '0;
            blink_q  <= 1'b0;
            synced_q <= 1'b0;
            cell_x_q <= '0;
            cell_y_q <= '0;
            inside_q <= 1'b0;
            edge_x_q <= 1'b0;
            edge_y_q <= 1'b0;
            flash_q  <= 1'b0;
            rgb_q    <= '0;
        end else begin
            sub_x_q  <= sub_x_d;
            col_q    <= col_d;
            sub_y_q  <= sub_y_d;
            row_q    <= row_d;
            frame_q  <= frame_d;
            blink_q  <= blink_d;
            synced_q <= synced_d;
            cell_x_q <= cell_x_d;
            cell_y_q <= cell_y_d;
            inside_q <= inside_d;
            edge_x_q <= edge_x_d;
            edge_y_q <= edge_y_d;
            flash_q  <= flash_d;
            rgb_q    <= rgb_d;
        end
    end

    assign bus.cell_x = cell_x_q;
    assign bus.cell_y = cell_y_q;
    assign bus.rgb    = rgb_q;
endmodule

// File: doc/playfield_renderer.md
PLAYFIELD_RENDERER -- requirements
Module: playfield_renderer

Interface
REQ-001 SHALL have parameter ORG_X, default 220, meaning the left pixel column of the board.
REQ-002 SHALL have parameter ORG_Y, default 40, meaning the top pixel row of the board.
REQ-003 SHALL have parameter CELL, default 20, meaning the cell edge in pixels (legal range 2..63).
REQ-004 SHALL have parameter COLS, default 10, and ROWS, default 20, meaning the board size in cells.
REQ-005 SHALL have parameter PALETTE, default {F00,80C,0F3,FF0,D90,04F,09D,000} (entry 7 down to 0, 12 bits each), meaning the kind-to-RGB map.
REQ-006 SHALL have parameters BG_RGB = 12'h111, GRID_RGB = 12'h333 and FLASH_RGB = 12'hFFF, meaning the background, grid-line and flash colours.
REQ-007 SHALL have parameter FLASH_FRAMES, default 8, meaning the number of frames per flash half-period.
REQ-008 clk  input  1  system clock (50 MHz pixel domain).
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 p_tick  input  1  pixel strobe; asserted at most every second clk.
REQ-011 visible  input  1  active video for the current pixel.
REQ-012 pixel_x, pixel_y  input  10 each  current pixel coordinate; pixel_x increments by 1 per p_tick within a line.
REQ-013 cell_x  output  $clog2(COLS)  board column being looked up; cell_y  output  $clog2(ROWS)  board row being looked up.
REQ-014 cell_kind  input  3  board content at (cell_x, cell_y); valid before the next p_tick.
REQ-015 grid_en  input  1  draws grid lines when 1.
REQ-016 row_flash  input  ROWS  rows that blink (line-clear effect).
REQ-017 rgb  output  12  registered pixel colour {R,G,B}.

Function
REQ-018 SHALL derive the cell index from running counters (sub_x, col, sub_y, row), not from dividers.
REQ-019 On p_tick with pixel_x == ORG_X: SHALL set sub_x = 0 and col = 0.
REQ-020 On any other p_tick: SHALL increment sub_x, wrapping at CELL-1, and SHALL increment col on each wrap.
REQ-021 On p_tick with pixel_x == ORG_X and pixel_y == ORG_Y: SHALL set sub_y = 0 and row = 0.
REQ-022 On p_tick with pixel_x == ORG_X and any other pixel_y: SHALL increment sub_y, wrapping at CELL-1, and SHALL increment row on each wrap.
REQ-023 inside SHALL be ORG_X <= pixel_x < ORG_X+COLS*CELL and ORG_Y <= pixel_y < ORG_Y+ROWS*CELL, ANDed with visible and the synced flag.
REQ-024 On each p_tick, stage 1 SHALL register cell_x = col, cell_y = row, inside, sub_x == 0, sub_y == 0 and row_flash[row].
REQ-025 cell_x and cell_y SHALL be held between p_ticks.
REQ-026 On the next p_tick, stage 2 SHALL register rgb using the stage-1 values and cell_kind; latency is exactly one p_tick from pixel presentation to rgb.
REQ-027 rgb priority SHALL be: not inside -> BG_RGB; grid_en and (sub_x == 0 or sub_y == 0) -> GRID_RGB; flagged row and blink phase 1 -> FLASH_RGB; otherwise PALETTE[cell_kind].
REQ-028 rgb SHALL change only on p_tick.
REQ-029 The frame counter SHALL advance on p_tick at pixel (0,0) and wrap at FLASH_FRAMES-1.
REQ-030 blink phase SHALL toggle on each frame-counter wrap.
REQ-031 synced SHALL clear on reset and SHALL set on the first p_tick at (ORG_X, ORG_Y); while synced = 0, every pixel SHALL render BG_RGB.
REQ-032 col and row SHALL saturate at COLS-1 and ROWS-1 outside the board and SHALL never index past them.
REQ-033 p_tick with visible = 0 SHALL still advance the counters and SHALL produce BG_RGB.

Reset
REQ-034 reset SHALL take priority over p_tick in the same cycle.
REQ-035 On reset: rgb = 12'h000, cell_x = 0, cell_y = 0, all counters 0, blink phase 0, synced 0.
REQ-036 Reset mid-frame SHALL yield BG_RGB until the next frame passes (ORG_X, ORG_Y).

Verification
REQ-037 Defaults, synced, pixel (220,40), cell_kind=1 -> cell_x=0, cell_y=0 one clk later; rgb=09D at the next p_tick.
REQ-038 Pixel (419,439) -> cell_x=9, cell_y=19; pixel (420,439) -> rgb=111; pixel (419,440) -> rgb=111.
REQ-039 grid_en=1, cell_kind=4: pixel (240,45) -> rgb=333; pixel (241,45) -> rgb=FF0; pixel (241,60) -> rgb=333.
REQ-040 FLASH_FRAMES=2, row_flash[3]=1, cell_kind=2, pixel (230,105) -> rgb=04F in frames 0-1, FFF in frames 2-3, 04F in frames 4-5; row 4 is unaffected.
REQ-041 Reset asserted at pixel (300,200) -> rgb=000 next clk; remainder of the frame renders 111; board resumes in the following frame.
REQ-042 p_tick coincident with reset -> counters stay 0; visible=0 inside board -> rgb=111.
